ir_mem_loader: RTL and testbench
================================

Name: ir_mem_loader

Overview:
- Upstream feeder of the instruction register file.
- After start, fetches a contiguous block of instruction words from program memory over a req/ack handshake.
- Writes each word into the IR regfile in order, then raises init-finished, which the regfile uses to leave its init state.
- Sits between the program memory port and the IR regfile write port.

Parameters:
- DATA_WIDTH, 16, instruction word width; matches the regfile data width.
- ADDR_WIDTH, 8, width of the memory and regfile address.
- LOAD_DEPTH, 16, number of words loaded per run; range 1..2^ADDR_WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle start pulse.
- i_base_addr  input  ADDR_WIDTH  first memory address; sampled on the accepted i_start.
- o_mem_req  output  1  memory read request; held until acknowledged.
- o_mem_addr  output  ADDR_WIDTH  memory read address; stable while o_mem_req=1.
- i_mem_ack  input  1  memory acknowledge; i_mem_data is valid in the same cycle.
- i_mem_data  input  DATA_WIDTH  memory read data.
- o_rf_we  output  1  regfile write strobe, one cycle per word.
- o_rf_addr  output  ADDR_WIDTH  regfile write index, 0..LOAD_DEPTH-1.
- o_rf_data  output  DATA_WIDTH  regfile write data.
- o_busy  output  1  load in progress.
- o_init_finished  output  1  all LOAD_DEPTH words written; level signal.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs 0; word counter 0; captured data 0.
  - Applies immediately, including mid-load. A partial load is abandoned and o_init_finished stays 0.
- States:
  - IDLE: o_busy=0. i_start=1 latches i_base_addr, clears the counter, and moves to REQ.
  - REQ: o_mem_req=1, o_mem_addr = base + count, modulo 2^ADDR_WIDTH (wraps silently). Stays in REQ until i_mem_ack=1. On ack, i_mem_data is captured and the state moves to WRITE.
  - WRITE: o_rf_we=1 for exactly one cycle, o_rf_addr=count, o_rf_data=captured word, o_mem_req=0.
    - If count==LOAD_DEPTH-1, go to DONE.
    - Otherwise count+1 and return to REQ.
  - DONE: o_init_finished=1, o_busy=0. i_start=1 clears o_init_finished in the next cycle and restarts exactly as from IDLE, with a new base latched.
- o_busy=1 in REQ and WRITE only.
- All outputs are registered (Moore): they are driven from state and registers, not from inputs.
- Timing, zero-wait memory (ack in the first REQ cycle):
  - First o_mem_req rises 1 cycle after the i_start edge.
  - Each word takes 2 cycles (REQ, WRITE).
  - o_init_finished rises 2*LOAD_DEPTH+1 cycles after the start edge.
- Handshake rules:
  - i_mem_ack outside REQ is ignored.
  - Data is sampled only on the ack cycle.
  - o_mem_addr must not change while o_mem_req=1 and no ack has arrived.
- i_start while o_busy=1 is ignored; the current load continues unaffected.
- LOAD_DEPTH=1: sequence is REQ, WRITE, DONE.

Optional Feature:
- Macro: IR_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output o_checksum [DATA_WIDTH-1:0].
  - Cleared to 0 on reset and on every accepted i_start.
  - Adds i_mem_data modulo 2^DATA_WIDTH on every ack cycle in REQ.
  - Value is final and stable when o_init_finished rises; it holds until the next start or reset.
- Not defined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Zero-wait load: LOAD_DEPTH=4, base=8'h10, ack tied to req, memory[a]=a+16'h0100.
  -> 4 writes: addr 0..3 with data 16'h0110..16'h0113; o_init_finished rises on cycle 9 after the start edge; o_mem_addr 10,11,12,13.
- Wait states: ack delayed 3 cycles per word.
  -> o_mem_req and o_mem_addr held stable during the wait; one o_rf_we per word; no duplicate or missing writes.
- Address wrap: base=8'hFE, LOAD_DEPTH=4.
  -> o_mem_addr FE, FF, 00, 01; o_rf_addr 0..3.
- Start while busy, plus stray ack: i_start pulsed mid-load; i_mem_ack pulsed while in WRITE.
  -> both ignored; write sequence unchanged.
- Reset mid-load: rst asserted after word 2 (async, between edges).
  -> all outputs 0 immediately. A new start loads from word 0 and o_init_finished rises only after the full load.
- Checksum (IR_LOADER_CHECKSUM_EN defined): words 16'h0001, 16'hFFFF, 16'h0010, 16'h0002.
  -> o_checksum=16'h0012 when o_init_finished rises; a restart clears it to 0.

Source files
------------

// File: rtl/ir_mem_loader.sv
// Instruction-memory loader: copies LOAD_DEPTH words from program memory into the IR regfile.
// Optional running checksum of the loaded words when IR_LOADER_CHECKSUM_EN is defined.
module ir_mem_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LOAD_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_rf_we,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    output logic [DATA_WIDTH-1:0] o_rf_data,
    output logic                  o_busy,
`ifdef IR_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] o_checksum,
`endif
    output logic                  o_init_finished
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LOAD_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  start_acc;

    // A start is only honoured when no load is running.
    assign start_acc = i_start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    base_d  = i_base_addr;
                    count_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_mem_ack) begin
                    data_d  = i_mem_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (count_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; address/data are zeroed outside their strobe.
    always_comb begin
        o_mem_req       = (state_q == REQ);
        o_mem_addr      = (state_q == REQ) ? (base_q + count_q) : '0;
        o_rf_we         = (state_q == WRITE);
        o_rf_addr       = (state_q == WRITE) ? count_q : '0;
        o_rf_data       = (state_q == WRITE) ? data_q : '0;
        o_busy          = (state_q == REQ) || (state_q == WRITE);
        o_init_finished = (state_q == DONE);
    end

`ifdef IR_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if ((state_q == REQ) && i_mem_ack) begin
            csum_d = csum_q + i_mem_data;
        end
    end

    assign o_checksum = csum_q;
`endif

endmodule

// File: tb/tb_ir_mem_loader.sv
// Randomized self-checking bench for ir_mem_loader against a word-sequence reference model.
module tb_ir_mem_loader;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_data;
    logic          o_rf_we;
    logic [AW-1:0] o_rf_addr;
    logic [DW-1:0] o_rf_data;
    logic          o_busy;
    logic          o_init_finished;
`ifdef IR_LOADER_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] mem [256];

    always #5 clk = ~clk;

    ir_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .o_mem_req       (o_mem_req),
        .o_mem_addr      (o_mem_addr),
        .i_mem_ack       (i_mem_ack),
        .i_mem_data      (i_mem_data),
        .o_rf_we         (o_rf_we),
        .o_rf_addr       (o_rf_addr),
        .o_rf_data       (o_rf_data),
        .o_busy          (o_busy),
`ifdef IR_LOADER_CHECKSUM_EN
        .o_checksum      (o_checksum),
`endif
        .o_init_finished (o_init_finished)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  32'(o_mem_req), 32'd0);
        chk({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
        chk({tag, "_we"},   32'(o_rf_we), 32'd0);
        chk({tag, "_rfa"},  32'(o_rf_addr), 32'd0);
        chk({tag, "_rfd"},  32'(o_rf_data), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_fin"},  32'(o_init_finished), 32'd0);
    endtask

    // One load: every memory word must appear exactly once, in order, at the right
    // address; with dly wait cycles per word the load ends DEPTH*(dly+2)+1 cycles after start.
    task automatic run_load(input logic [AW-1:0] base, input int dly, input bit stray,
                            input bit busy_start, input int abort_at);
        int            widx = 0;
        int            wait_cnt = 0;
        bit            fin = 0;
        logic [DW-1:0] sum = '0;
        @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = base;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge clk);
            i_start    = 1'b0;
            i_mem_ack  = 1'b0;
            i_mem_data = '0;
`ifdef IR_LOADER_CHECKSUM_EN
            if (cyc == 1) chk("csum_clear", 32'(o_checksum), 32'd0);
`endif
            if (o_init_finished) begin
                fin = 1;
                chk("fin_cycle", 32'(cyc), 32'(DEPTH * (dly + 2) + 1));
                chk("fin_words", 32'(widx), 32'(DEPTH));
                chk("fin_busy",  32'(o_busy), 32'd0);
`ifdef IR_LOADER_CHECKSUM_EN
                chk("csum", 32'(o_checksum), 32'(sum));
`endif
            end else begin
                chk("busy", 32'(o_busy), 32'd1);
                if (o_mem_req) begin
                    chk("mem_addr", 32'(o_mem_addr), 32'(AW'(base + AW'(widx))));
                    chk("req_we_excl", 32'(o_rf_we), 32'd0);
                    if (wait_cnt == dly) begin
                        i_mem_ack  = 1'b1;
                        i_mem_data = mem[o_mem_addr];
                    end else begin
                        wait_cnt++;
                    end
                end else if (o_rf_we) begin
                    chk("rf_addr", 32'(o_rf_addr), 32'(widx));
                    chk("rf_data", 32'(o_rf_data), 32'(mem[AW'(base + AW'(widx))]));
                    sum = sum + mem[AW'(base + AW'(widx))];
                    widx++;
                    wait_cnt = 0;
                    if (stray) begin
                        i_mem_ack  = 1'b1;
                        i_mem_data = 16'hDEAD;
                    end
                end else begin
                    chk("req_or_we", 32'd0, 32'd1);
                end
                if (busy_start && cyc == 3) begin
                    i_start     = 1'b1;
                    i_base_addr = ~base;
                end
                if (abort_at >= 0 && widx == abort_at) begin
                    #1 rst = 1'b1;
                    #1 chk_all_zero("rst_mid");
                    i_mem_ack = 1'b0;
                    return;
                end
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("fin_hold", 32'(o_init_finished), 32'd1);
        chk("fin_no_we", 32'(o_rf_we), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_mem_ack   = 1'b0;
        i_mem_data  = '0;
        for (int a = 0; a < 256; a++) mem[a] = DW'(a + 16'h0100);
        #3 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_load(8'h10, 0, 1'b0, 1'b0, -1);           // zero-wait
        run_load(AW'($urandom_range(0, 255)), 3, 1'b0, 1'b0, -1);  // wait states
        run_load(8'hFE, 1, 1'b0, 1'b0, -1);           // address wrap
        run_load(8'h40, 2, 1'b1, 1'b1, -1);           // start while busy + stray ack
        run_load(8'h40, 0, 1'b1, 1'b1, -1);

        run_load(8'h20, 1, 1'b0, 1'b0, 2);            // reset mid-load
        @(negedge clk);
        chk_all_zero("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_fin", 32'(o_init_finished), 32'd0);
        run_load(8'h20, 0, 1'b0, 1'b0, -1);

        mem[8'h80] = 16'h0001;
        mem[8'h81] = 16'hFFFF;
        mem[8'h82] = 16'h0010;
        mem[8'h83] = 16'h0002;
        run_load(8'h80, 0, 1'b0, 1'b0, -1);
`ifdef IR_LOADER_CHECKSUM_EN
        chk("csum_fixed", 32'(o_checksum), 32'h0012);
`endif

        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
            run_load(AW'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
